piece_controller: RTL and testbench

Sequencer for the falling tetromino. It owns the active piece's reference point (`ref_x`, `ref_y`) and drives the playfield/colour-mux block that tracks occupancy and reports collisions. It spawns pieces, applies gravity ticks and left/right/soft-drop key moves, and honours that block's blocked-below (`stop`) and side-collision (`hit_left`/`hit_right`) flags. It handshakes the lock and line-clear phase and detects game over. It sits between the debounced key inputs and the playfield block, in the VGA clock domain.

---
 rtl/tetris_pkg.sv | 19 +
 rtl/drop_timer.sv | 34 +++
 rtl/piece_controller.sv | 166 ++++++++++++++++
 tb/tb_piece_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Constants and state encoding shared by the piece controller and the playfield/colour-mux block.
package tetris_pkg;

    localparam int unsigned BLOCK_PX = 20;
    localparam int unsigned FIELD_W  = 640;
    localparam int unsigned FIELD_H  = 480;
    localparam int unsigned SPAWN_X  = 280;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StSpawn     = 3'd1,
        StSettle    = 3'd2,
        StFall      = 3'd3,
        StLock      = 3'd4,
        StClearWait = 3'd5,
        StOver      = 3'd6
    } pc_state_t;

endpackage

// File: rtl/drop_timer.sv
// Gravity divider: counts up while not held, saturates at the current limit and reports tick.
module drop_timer #(
    parameter int unsigned DROP_DIV = 12_500_000,
    parameter int unsigned FAST_DIV = 1_250_000
) (
    input  logic iVGA_CLK,
    input  logic reset,
    input  logic clear,
    input  logic fast,
    input  logic hold,
    output logic tick
);

    logic [23:0] count;
    logic [23:0] limit;

    always_comb begin
        limit = fast ? 24'(FAST_DIV - 1) : 24'(DROP_DIV - 1);
    end

    // Compared against the live limit, so a count already past a new shorter limit fires at once.
    assign tick = (count >= limit);

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!hold && !tick) begin
            count <= count + 24'd1;
        end
    end

endmodule

// File: rtl/piece_controller.sv
// Falling-piece sequencer: spawn, gravity, horizontal moves, lock/clear handshake and game over.
module piece_controller
    import tetris_pkg::*;
#(
    parameter int unsigned BLOCK    = tetris_pkg::BLOCK_PX,
    parameter int unsigned SPAWN_X  = tetris_pkg::SPAWN_X,
    parameter int unsigned FIELD_H  = tetris_pkg::FIELD_H,
    parameter int unsigned DROP_DIV = 12_500_000,
    parameter int unsigned FAST_DIV = 1_250_000,
    parameter int unsigned SETTLE   = 2
) (
    input  logic       iVGA_CLK,
    input  logic       reset,
    input  logic       start,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_down,
    input  logic       stop,
    input  logic       hit_left,
    input  logic       hit_right,
    input  logic       clear_busy,
    output logic [9:0] ref_x,
    output logic [9:0] ref_y,
    output logic       change_shape,
    output logic       lock,
    output logic       game_over,
    output logic [2:0] state
);

    pc_state_t  state_q;
    logic       left_s, left_p, right_s, right_p;
    logic       left_pend, right_pend;
    logic [7:0] settle_cnt;
    logic       from_spawn;
    logic       cw_first;

    logic left_edge, right_edge, want_left, want_right, go_left, go_right;
    logic at_floor, tick, timer_clear, timer_hold;

    assign state = state_q;

    always_comb begin
        left_edge   = left_s & ~left_p;
        right_edge  = right_s & ~right_p;
        want_left   = left_edge | left_pend;
        want_right  = right_edge | right_pend;
        go_left     = want_left & ~want_right & ~hit_left & (ref_x >= 10'(BLOCK));
        go_right    = want_right & ~want_left & ~hit_right;
        at_floor    = ({1'b0, ref_y} + 11'(BLOCK)) >= 11'(FIELD_H);
        // Outside FALL the divider is frozen; a tick lost to a move stays saturated until next FALL.
        timer_hold  = (state_q != StFall);
        timer_clear = (state_q == StSpawn) ||
                      ((state_q == StFall) && tick && !go_left && !go_right);
    end

    drop_timer #(
        .DROP_DIV (DROP_DIV),
        .FAST_DIV (FAST_DIV)
    ) u_drop_timer (
        .iVGA_CLK (iVGA_CLK),
        .reset    (reset),
        .clear    (timer_clear),
        .fast     (key_down),
        .hold     (timer_hold),
        .tick     (tick)
    );

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ref_x        <= 10'(SPAWN_X);
            ref_y        <= '0;
            change_shape <= 1'b0;
            lock         <= 1'b0;
            game_over    <= 1'b0;
            left_s       <= 1'b0;
            left_p       <= 1'b0;
            right_s      <= 1'b0;
            right_p      <= 1'b0;
            left_pend    <= 1'b0;
            right_pend   <= 1'b0;
            settle_cnt   <= '0;
            from_spawn   <= 1'b0;
            cw_first     <= 1'b0;
        end else begin
            left_s       <= key_left;
            left_p       <= left_s;
            right_s      <= key_right;
            right_p      <= right_s;
            change_shape <= 1'b0;
            lock         <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StSpawn;
                        change_shape <= 1'b1;
                    end
                end
                StSpawn: begin
                    ref_x      <= 10'(SPAWN_X);
                    ref_y      <= '0;
                    settle_cnt <= '0;
                    from_spawn <= 1'b1;
                    left_pend  <= 1'b0;
                    right_pend <= 1'b0;
                    state_q    <= StSettle;
                end
                StSettle: begin
                    if (left_edge) left_pend <= 1'b1;
                    if (right_edge) right_pend <= 1'b1;
                    if (settle_cnt == 8'(SETTLE - 1)) begin
                        if (from_spawn && stop) begin
                            state_q   <= StOver;
                            game_over <= 1'b1;
                        end else begin
                            state_q <= StFall;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                StFall: begin
                    left_pend  <= 1'b0;
                    right_pend <= 1'b0;
                    if (go_left || go_right) begin
                        ref_x      <= go_left ? ref_x - 10'(BLOCK) : ref_x + 10'(BLOCK);
                        settle_cnt <= '0;
                        from_spawn <= 1'b0;
                        state_q    <= StSettle;
                    end else if (tick) begin
                        if (stop || at_floor) begin
                            state_q <= StLock;
                            lock    <= 1'b1;
                        end else begin
                            ref_y      <= ref_y + 10'(BLOCK);
                            settle_cnt <= '0;
                            from_spawn <= 1'b0;
                            state_q    <= StSettle;
                        end
                    end
                end
                StLock: begin
                    cw_first <= 1'b1;
                    state_q  <= StClearWait;
                end
                StClearWait: begin
                    left_pend  <= 1'b0;
                    right_pend <= 1'b0;
                    cw_first   <= 1'b0;
                    if (!cw_first && !clear_busy) begin
                        state_q      <= StSpawn;
                        change_shape <= 1'b1;
                    end
                end
                StOver: begin
                    game_over <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_controller.sv
// Bench for piece_controller: directed stimulus, per-cycle behavioural monitor and literal checks.
module tb_piece_controller;
    import tetris_pkg::*;

    localparam int BLK = 20;

    logic       clk = 1'b0;
    logic       reset, start, key_left, key_right, key_down;
    logic       stop, hit_left, hit_right, clear_busy;
    logic [9:0] ref_x, ref_y;
    logic       change_shape, lock, game_over;
    logic [2:0] state;

    always #5 clk = ~clk;

    piece_controller #(
        .DROP_DIV (8),
        .FAST_DIV (2),
        .SETTLE   (2)
    ) dut (
        .iVGA_CLK     (clk),
        .reset        (reset),
        .start        (start),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_down     (key_down),
        .stop         (stop),
        .hit_left     (hit_left),
        .hit_right    (hit_right),
        .clear_busy   (clear_busy),
        .ref_x        (ref_x),
        .ref_y        (ref_y),
        .change_shape (change_shape),
        .lock         (lock),
        .game_over    (game_over),
        .state        (state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Behavioural model state, updated by the monitor.
    bit         prev_valid = 1'b0;
    logic [2:0] prev_state;
    int         prev_x, prev_y;
    bit         prev_lock, prev_shape;
    int         fall_cycles = 0;
    int         last_div = 8;
    int         lock_cnt = 0;
    int         shape_cnt = 0;
    bit         spacing_on = 1'b0;

    always @(negedge clk) begin
        int dx;
        int dy;
        bit ok;
        dx = 0;
        dy = 0;
        if (reset) begin
            prev_valid  = 1'b0;
            fall_cycles = 0;
            lock_cnt    = 0;
            shape_cnt   = 0;
        end else begin
            chk("ref_x_grid", int'(ref_x) % BLK, 0);
            chk("ref_y_grid", int'(ref_y) % BLK, 0);
            chk("ref_y_range", int'(int'(ref_y) <= 460), 1);
            chk("game_over_vs_state", int'(game_over), int'(state == StOver));
            if (prev_valid) begin
                dx = int'(ref_x) - prev_x;
                dy = int'(ref_y) - prev_y;
                if (prev_state == StFall)
                    ok = (dx == 0 && (dy == 0 || dy == BLK)) ||
                         (dy == 0 && (dx == BLK || dx == -BLK));
                else if (prev_state == StSpawn)
                    ok = (ref_x == 10'd280 && ref_y == 10'd0);
                else
                    ok = (dx == 0 && dy == 0);
                chk("ref_step", int'(ok), 1);
                if (spacing_on && dy == BLK) chk("tick_spacing", fall_cycles, last_div);
            end
            if (lock) begin
                chk("lock_single_cycle", int'(prev_lock), 0);
                chk("lock_per_piece", lock_cnt, shape_cnt - 1);
                if (spacing_on) chk("floor_tick_spacing", fall_cycles, last_div);
                lock_cnt++;
            end
            if (change_shape) begin
                chk("shape_single_cycle", int'(prev_shape), 0);
                shape_cnt++;
            end
            if (state == StSpawn || dy != 0) begin
                fall_cycles = 0;
            end else if (state == StFall) begin
                fall_cycles++;
                last_div = key_down ? 2 : 8;
            end
            prev_valid = 1'b1;
            prev_state = state;
            prev_x     = int'(ref_x);
            prev_y     = int'(ref_y);
            prev_lock  = lock;
            prev_shape = change_shape;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit l, input bit r);
        key_left  = l;
        key_right = r;
        cyc(1);
        key_left  = 1'b0;
        key_right = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; key_left = 1'b0; key_right = 1'b0; key_down = 1'b0;
        stop = 1'b0; hit_left = 1'b0; hit_right = 1'b0; clear_busy = 1'b0;
        cyc(3);
        chk("rst_ref_x", int'(ref_x), 280);
        chk("rst_ref_y", int'(ref_y), 0);
        chk("rst_state", int'(state), int'(StIdle));
        chk("rst_outputs", int'({change_shape, lock, game_over}), 0);
        reset = 1'b0;
        cyc(2);
        chk("idle_hold", int'(state), int'(StIdle));

        // Spawn
        start = 1'b1;
        cyc(1);
        chk("spawn_state", int'(state), int'(StSpawn));
        chk("spawn_shape_pulse", int'(change_shape), 1);
        start = 1'b0;
        cyc(1);
        chk("settle_state", int'(state), int'(StSettle));
        chk("shape_pulse_end", int'(change_shape), 0);
        chk("spawn_ref_x", int'(ref_x), 280);
        chk("spawn_ref_y", int'(ref_y), 0);
        cyc(1);
        chk("settle_state2", int'(state), int'(StSettle));
        cyc(1);
        chk("fall_state", int'(state), int'(StFall));
        spacing_on = 1'b1;

        // Gravity: 8 FALL cycles per tick, 2 SETTLE cycles between
        cyc(7);
        chk("grav_before_tick1", int'(ref_y), 0);
        cyc(1);
        chk("grav_tick1", int'(ref_y), 20);
        cyc(9);
        chk("grav_before_tick2", int'(ref_y), 20);
        cyc(1);
        chk("grav_tick2", int'(ref_y), 40);
        cyc(1);
        key_down = 1'b1;

        // Floor
        for (int i = 0; i < 400; i++) begin
            if (lock) break;
            cyc(1);
        end
        chk("floor_lock", int'(lock), 1);
        chk("floor_ref_y", int'(ref_y), 460);
        chk("floor_state", int'(state), int'(StLock));
        clear_busy = 1'b1;
        key_down   = 1'b0;
        spacing_on = 1'b0;
        cyc(1);
        chk("lock_pulse_end", int'(lock), 0);
        chk("clear_wait_state", int'(state), int'(StClearWait));

        // Line-clear handshake
        cyc(4);
        chk("clear_busy_hold", int'(state), int'(StClearWait));
        clear_busy = 1'b0;
        cyc(1);
        chk("respawn_state", int'(state), int'(StSpawn));
        chk("respawn_shape", int'(change_shape), 1);
        cyc(1);
        chk("respawn_ref_y", int'(ref_y), 0);
        chk("respawn_ref_x", int'(ref_x), 280);
        cyc(2);
        chk("respawn_fall", int'(state), int'(StFall));

        // Left moves
        key_left = 1'b1;
        cyc(1);
        chk("left_latency1", int'(ref_x), 280);
        cyc(1);
        chk("left_move", int'(ref_x), 260);
        key_left = 1'b0;
        cyc(3);
        hit_left = 1'b1;
        press(1'b1, 1'b0);
        cyc(5);
        chk("left_blocked", int'(ref_x), 260);
        hit_left = 1'b0;
        for (int i = 0; i < 13; i++) begin
            press(1'b1, 1'b0);
            cyc(5);
        end
        chk("left_to_wall", int'(ref_x), 0);
        press(1'b1, 1'b0);
        cyc(5);
        chk("left_at_wall", int'(ref_x), 0);
        press(1'b0, 1'b1);
        cyc(5);
        chk("right_move", int'(ref_x), 20);
        press(1'b1, 1'b1);
        cyc(5);
        chk("both_edges", int'(ref_x), 20);

        // Game over
        stop = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (lock) break;
            cyc(1);
        end
        chk("stop_lock", int'(lock), 1);
        for (int i = 0; i < 30; i++) begin
            if (game_over) break;
            cyc(1);
        end
        chk("game_over", int'(game_over), 1);
        chk("over_state", int'(state), int'(StOver));
        chk("over_lock_count", lock_cnt, 2);
        chk("over_shape_count", shape_cnt, 3);
        start = 1'b1;
        cyc(3);
        chk("over_ignores_start", int'(state), int'(StOver));
        chk("over_sticky", int'(game_over), 1);
        chk("over_no_respawn", shape_cnt, 3);
        start = 1'b0;

        // Asynchronous reset from OVER
        reset = 1'b1;
        #2;
        chk("async_reset_state", int'(state), int'(StIdle));
        chk("async_reset_over", int'(game_over), 0);
        cyc(2);
        reset = 1'b0;
        stop  = 1'b0;
        chk("post_reset_ref_x", int'(ref_x), 280);
        chk("post_reset_ref_y", int'(ref_y), 0);
        chk("post_reset_pulses", int'({change_shape, lock}), 0);
        cyc(2);
        chk("post_reset_idle", int'(state), int'(StIdle));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
